io_window_decoder: RTL and testbench

//  Next-generation Dock I/O decoder. It maps CPU I/O cycles to slot chip-selects through NUM_WIN programmable base/mask windows.

---
 rtl/io_window_decoder.sv | 239 +++++++++++++++++++++++
 tb/tb_io_window_decoder.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/io_window_decoder.sv
// io_window_decoder: maps CPU I/O cycles onto slot chip-selects through
// NUM_WIN programmable base/mask windows (lowest index wins). A bus-cycle FSM
// holds the CPU via ready_n for the window's wait states and until the slot
// reports ready; a watchdog forces completion of hung cycles.
// Ports:
//   clk, rst_n                  clock, async active-low reset
//   addr, iorq_n, r_w_          CPU I/O bus
//   dev_ready_n                 per-slot ready (1 = ready)
//   cfg_we/cfg_addr/cfg_wdata   single-clock config write port
//   cfg_rdata                   combinational config readback
//   cs_n, ready_n, io_r_w_,
//   data_oe_n, data_dir         registered slot/CPU controls
//   irq_err                     OR of sticky timeout/nomatch flags
module io_window_decoder #(
  parameter int unsigned ADDR_W    = 8,
  parameter int unsigned NUM_WIN   = 4,
  parameter int unsigned NUM_SLOTS = 5,
  parameter int unsigned TIMEOUT   = 64
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [ADDR_W-1:0]    addr,
  input  logic                 iorq_n,
  input  logic                 r_w_,
  input  logic [NUM_SLOTS-1:0] dev_ready_n,
  input  logic                 cfg_we,
  input  logic [7:0]           cfg_addr,
  input  logic [15:0]          cfg_wdata,
  output logic [15:0]          cfg_rdata,
  output logic [NUM_SLOTS-1:0] cs_n,
  output logic                 ready_n,
  output logic                 io_r_w_,
  output logic                 data_oe_n,
  output logic                 data_dir,
  output logic                 irq_err
);

  localparam int unsigned WIN_W  = (NUM_WIN > 1) ? $clog2(NUM_WIN) : 1;
  localparam int unsigned TCNT_W = $clog2(TIMEOUT);

  typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_DONE} state_t;

  // Window configuration tables
  logic [ADDR_W-1:0]  r_base   [NUM_WIN];
  logic [ADDR_W-1:0]  r_mask   [NUM_WIN];
  logic [3:0]         r_slot_t [NUM_WIN];
  logic [3:0]         r_wait   [NUM_WIN];
  logic [NUM_WIN-1:0] r_en, r_wr_ok, r_rd_ok;

  // Bus-cycle state and status
  state_t             r_state;
  logic [3:0]         r_slot;
  logic [3:0]         r_wcnt;
  logic [TCNT_W-1:0]  r_tcnt;
  logic [7:0]         r_hit_cnt;
  logic [3:0]         r_last_win;
  logic               r_timeout, r_nomatch;

  logic [2:0]         w_tbl;
  logic               w_idx_ok;
  logic [WIN_W-1:0]   w_idx;
  logic               w_stat_we;
  logic [NUM_WIN-1:0] w_match;
  logic               w_hit;
  logic [WIN_W-1:0]   w_win;
  logic [3:0]         w_slot;
  logic [3:0]         w_wait;
  logic [NUM_SLOTS-1:0] w_cs_sel;
  logic               w_dev_rdy;
  logic               w_unused_ok;

  assign w_tbl     = cfg_addr[7:5];
  assign w_idx_ok  = 32'(cfg_addr[4:0]) < NUM_WIN;
  assign w_idx     = WIN_W'(cfg_addr[4:0]);
  assign w_stat_we = cfg_we && (w_tbl == 3'd7);
  assign irq_err   = r_timeout | r_nomatch;
  assign w_unused_ok = ^cfg_wdata;

  // Per-window match terms
  always_comb begin
    w_match = '0;
    for (int i = 0; i < int'(NUM_WIN); i++) begin
      w_match[i] = r_en[i] &&
                   ((addr & r_mask[i]) == (r_base[i] & r_mask[i])) &&
                   (r_w_ ? r_rd_ok[i] : r_wr_ok[i]) &&
                   (32'(r_slot_t[i]) < NUM_SLOTS);
    end
  end

  // Priority pick: scan downwards so the lowest matching index is the last written
  always_comb begin
    w_hit  = 1'b0;
    w_win  = '0;
    w_slot = '0;
    w_wait = '0;
    for (int i = int'(NUM_WIN) - 1; i >= 0; i--) begin
      if (w_match[i]) begin
        w_hit  = 1'b1;
        w_win  = WIN_W'(i);
        w_slot = r_slot_t[i];
        w_wait = r_wait[i];
      end
    end
  end

  // One-hot chip-select for the winning slot, and ready of the latched slot
  always_comb begin
    w_cs_sel  = '0;
    w_dev_rdy = 1'b0;
    for (int s = 0; s < int'(NUM_SLOTS); s++) begin
      w_cs_sel[s] = (4'(s) == w_slot);
      if (4'(s) == r_slot) w_dev_rdy = dev_ready_n[s];
    end
  end

  // Config readback
  always_comb begin
    cfg_rdata = '0;
    if (w_tbl == 3'd7) begin
      cfg_rdata = {r_hit_cnt, 2'b00, r_nomatch, r_timeout, r_last_win};
    end else if (w_idx_ok) begin
      case (w_tbl)
        3'd0:    cfg_rdata = 16'(r_base[w_idx]);
        3'd1:    cfg_rdata = 16'(r_mask[w_idx]);
        3'd2:    cfg_rdata = {8'h00, r_en[w_idx], r_wr_ok[w_idx], r_rd_ok[w_idx],
                              1'b0, r_slot_t[w_idx]};
        3'd3:    cfg_rdata = {12'h000, r_wait[w_idx]};
        default: cfg_rdata = '0;
      endcase
    end
  end

  // Window table writes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(NUM_WIN); i++) begin
        r_base[i]   <= '0;
        r_mask[i]   <= '0;
        r_slot_t[i] <= '0;
        r_wait[i]   <= '0;
      end
      r_en    <= '0;
      r_wr_ok <= '0;
      r_rd_ok <= '0;
    end else if (cfg_we && w_idx_ok) begin
      case (w_tbl)
        3'd0: r_base[w_idx] <= ADDR_W'(cfg_wdata);
        3'd1: r_mask[w_idx] <= ADDR_W'(cfg_wdata);
        3'd2: begin
          r_en[w_idx]     <= cfg_wdata[7];
          r_wr_ok[w_idx]  <= cfg_wdata[6];
          r_rd_ok[w_idx]  <= cfg_wdata[5];
          r_slot_t[w_idx] <= cfg_wdata[3:0];
        end
        3'd3: r_wait[w_idx] <= cfg_wdata[3:0];
        default: ;
      endcase
    end
  end

  // Bus-cycle FSM with registered outputs and sticky status
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_slot     <= '0;
      r_wcnt     <= '0;
      r_tcnt     <= '0;
      r_hit_cnt  <= '0;
      r_last_win <= '0;
      r_timeout  <= 1'b0;
      r_nomatch  <= 1'b0;
      cs_n       <= '1;
      ready_n    <= 1'b1;
      io_r_w_    <= 1'b1;
      data_oe_n  <= 1'b1;
      data_dir   <= 1'b1;
    end else begin
      // W1C clears come first so a same-cycle flag set overrides them
      if (w_stat_we) begin
        if (cfg_wdata[5]) r_nomatch <= 1'b0;
        if (cfg_wdata[4]) r_timeout <= 1'b0;
      end
      case (r_state)
        S_IDLE: begin
          if (!iorq_n) begin
            r_slot <= w_slot;
            r_wcnt <= w_wait;
            r_tcnt <= '0;
            if (w_hit) begin
              r_state    <= S_ACTIVE;
              cs_n       <= ~w_cs_sel;
              ready_n    <= 1'b0;
              data_oe_n  <= 1'b0;
              io_r_w_    <= r_w_;
              data_dir   <= r_w_;
              r_hit_cnt  <= r_hit_cnt + 8'd1;
              r_last_win <= 4'(w_win);
            end else begin
              r_state   <= S_DONE;
              r_nomatch <= 1'b1;
            end
          end
        end
        S_ACTIVE: begin
          r_tcnt <= r_tcnt + TCNT_W'(1);
          if (iorq_n) begin
            r_state   <= S_IDLE;
            cs_n      <= '1;
            ready_n   <= 1'b1;
            io_r_w_   <= 1'b1;
            data_oe_n <= 1'b1;
            data_dir  <= 1'b1;
          end else if (r_tcnt == TCNT_W'(TIMEOUT - 1)) begin
            r_state   <= S_DONE;
            ready_n   <= 1'b1;
            r_timeout <= 1'b1;
          end else if (r_wcnt != 4'd0) begin
            r_wcnt <= r_wcnt - 4'd1;
          end else if (w_dev_rdy) begin
            r_state <= S_DONE;
            ready_n <= 1'b1;
          end
        end
        S_DONE: begin
          ready_n <= 1'b1;
          if (iorq_n) begin
            r_state   <= S_IDLE;
            cs_n      <= '1;
            io_r_w_   <= 1'b1;
            data_oe_n <= 1'b1;
            data_dir  <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_io_window_decoder.sv
// Directed testbench for io_window_decoder with hand-computed expectations.
module tb_io_window_decoder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  addr;
  logic        iorq_n;
  logic        r_w_;
  logic [4:0]  dev_ready_n;
  logic        cfg_we;
  logic [7:0]  cfg_addr;
  logic [15:0] cfg_wdata;
  logic [15:0] cfg_rdata;
  logic [4:0]  cs_n;
  logic        ready_n, io_r_w_, data_oe_n, data_dir, irq_err;

  int n_checks = 0;
  int n_fail   = 0;

  io_window_decoder dut (
    .clk(clk), .rst_n(rst_n), .addr(addr), .iorq_n(iorq_n), .r_w_(r_w_),
    .dev_ready_n(dev_ready_n), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_wdata(cfg_wdata), .cfg_rdata(cfg_rdata), .cs_n(cs_n),
    .ready_n(ready_n), .io_r_w_(io_r_w_), .data_oe_n(data_oe_n),
    .data_dir(data_dir), .irq_err(irq_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_wr(input logic [7:0] a, input logic [15:0] d);
    cfg_addr = a; cfg_wdata = d; cfg_we = 1'b1;
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic bus_start(input logic [7:0] a, input logic rw);
    addr = a; r_w_ = rw; iorq_n = 1'b0;
    tick();
  endtask

  task automatic bus_end();
    iorq_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; iorq_n = 1'b1; addr = '0; r_w_ = 1'b1; dev_ready_n = '1;
    cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0;
    #12;
    n_checks++;
    if ({cs_n, ready_n, io_r_w_, data_oe_n, data_dir, irq_err} !== 10'b11111_1111_0) begin
      n_fail++; $display("FAIL reset_outputs: got %b want 1111111110",
                         {cs_n, ready_n, io_r_w_, data_oe_n, data_dir, irq_err});
    end
    rst_n = 1'b1;
    tick();
    cfg_addr = 8'hE0; #1;
    n_checks++;
    if (cfg_rdata !== 16'h0000) begin n_fail++; $display("FAIL reset_status: got %h want 0000", cfg_rdata); end
    cfg_addr = 8'h40; #1;
    n_checks++;
    if (cfg_rdata !== 16'h0000) begin n_fail++; $display("FAIL reset_attr: got %h want 0000", cfg_rdata); end
  endtask

  task automatic test_cfg_readback();
    cfg_wr(8'h00, 16'hAB10);  // base[0]: only 8 bits kept
    cfg_wr(8'h20, 16'h00F0);  // mask[0]
    cfg_wr(8'h40, 16'h00E1);  // attr[0]: en, wr, rd, slot1
    cfg_wr(8'h42, 16'hFFFF);  // attr[2]: enabled but slot 15 is out of range
    cfg_wr(8'h62, 16'hFFF3);  // wait[2]
    cfg_wr(8'h05, 16'hFFFF);  // index >= NUM_WIN: ignored
    cfg_addr = 8'h00; #1; n_checks++;
    if (cfg_rdata !== 16'h0010) begin n_fail++; $display("FAIL rb_base: got %h want 0010", cfg_rdata); end
    cfg_addr = 8'h20; #1; n_checks++;
    if (cfg_rdata !== 16'h00F0) begin n_fail++; $display("FAIL rb_mask: got %h want 00f0", cfg_rdata); end
    cfg_addr = 8'h42; #1; n_checks++;
    if (cfg_rdata !== 16'h00EF) begin n_fail++; $display("FAIL rb_attr2: got %h want 00ef", cfg_rdata); end
    cfg_addr = 8'h62; #1; n_checks++;
    if (cfg_rdata !== 16'h0003) begin n_fail++; $display("FAIL rb_wait2: got %h want 0003", cfg_rdata); end
    cfg_addr = 8'h05; #1; n_checks++;
    if (cfg_rdata !== 16'h0000) begin n_fail++; $display("FAIL rb_bad_idx: got %h want 0000", cfg_rdata); end
    cfg_addr = 8'h80; #1; n_checks++;
    if (cfg_rdata !== 16'h0000) begin n_fail++; $display("FAIL rb_tbl4: got %h want 0000", cfg_rdata); end
  endtask

  task automatic test_basic_read();
    bus_start(8'h13, 1'b1);
    n_checks++;
    if ({cs_n, ready_n, data_oe_n, io_r_w_, data_dir} !== 9'b11101_0011) begin
      n_fail++; $display("FAIL read_select: got %b want 111010011", {cs_n, ready_n, data_oe_n, io_r_w_, data_dir});
    end
    tick();
    n_checks++;
    if ({cs_n, ready_n} !== 6'b11101_1) begin
      n_fail++; $display("FAIL read_done: got %b want 111011", {cs_n, ready_n});
    end
    bus_end();
    n_checks++;
    if ({cs_n, ready_n, data_oe_n} !== 7'b11111_11) begin
      n_fail++; $display("FAIL read_release: got %b want 1111111", {cs_n, ready_n, data_oe_n});
    end
  endtask

  task automatic test_priority();
    cfg_wr(8'h01, 16'h0010);
    cfg_wr(8'h21, 16'h00F0);
    cfg_wr(8'h41, 16'h00E2);
    bus_start(8'h12, 1'b1);
    n_checks++;
    if (cs_n !== 5'b11101) begin n_fail++; $display("FAIL prio_win0: got %b want 11101", cs_n); end
    tick(); bus_end();
    cfg_wr(8'h40, 16'h0061);  // drop win0 enable
    bus_start(8'h12, 1'b1);
    n_checks++;
    if (cs_n !== 5'b11011) begin n_fail++; $display("FAIL prio_win1: got %b want 11011", cs_n); end
    tick(); bus_end();
    cfg_addr = 8'hE0; #1; n_checks++;
    if (cfg_rdata !== 16'h0301) begin n_fail++; $display("FAIL prio_status: got %h want 0301", cfg_rdata); end
  endtask

  task automatic test_write_gating();
    cfg_wr(8'h40, 16'h00A1);  // win0 read-only
    cfg_wr(8'h41, 16'h0000);  // win1 off
    cfg_wr(8'h43, 16'h00E4);  // win3 catch-all, slot4
    bus_start(8'h10, 1'b0);
    n_checks++;
    if ({cs_n, io_r_w_, data_dir, data_oe_n} !== 8'b01111_000) begin
      n_fail++; $display("FAIL write_catchall: got %b want 01111000", {cs_n, io_r_w_, data_dir, data_oe_n});
    end
    tick(); bus_end();
    n_checks++;
    if ({io_r_w_, data_dir} !== 2'b11) begin
      n_fail++; $display("FAIL write_idle_dir: got %b want 11", {io_r_w_, data_dir});
    end
    bus_start(8'h10, 1'b1);
    n_checks++;
    if (cs_n !== 5'b11101) begin n_fail++; $display("FAIL read_rdonly_win: got %b want 11101", cs_n); end
    tick(); bus_end();
    cfg_addr = 8'hE0; #1; n_checks++;
    if (cfg_rdata !== 16'h0500) begin n_fail++; $display("FAIL gating_status: got %h want 0500", cfg_rdata); end
  endtask

  task automatic test_wait_states();
    int n;
    cfg_wr(8'h40, 16'h00E1);
    cfg_wr(8'h43, 16'h0000);
    cfg_wr(8'h60, 16'h0003);
    bus_start(8'h13, 1'b1);
    n = 0;
    while (ready_n === 1'b0 && n < 20) begin n++; tick(); end
    n_checks++;
    if (n != 4) begin n_fail++; $display("FAIL wait3_len: got %0d want 4", n); end
    bus_end();
    cfg_addr = 8'hE0; #1; n_checks++;
    if (cfg_rdata !== 16'h0600) begin n_fail++; $display("FAIL wait3_hits: got %h want 0600", cfg_rdata); end
    // Device not ready for two cycles with no wait states
    cfg_wr(8'h60, 16'h0000);
    dev_ready_n = 5'b11101;
    bus_start(8'h13, 1'b1);
    tick(); tick();
    n_checks++;
    if (ready_n !== 1'b0) begin n_fail++; $display("FAIL notready_hold: got %b want 0", ready_n); end
    dev_ready_n = 5'b11111;
    tick();
    n_checks++;
    if (ready_n !== 1'b1) begin n_fail++; $display("FAIL notready_done: got %b want 1", ready_n); end
    bus_end();
  endtask

  task automatic test_timeout();
    int n;
    dev_ready_n = 5'b11101;
    bus_start(8'h13, 1'b1);
    n = 0;
    while (ready_n === 1'b0 && n < 200) begin n++; tick(); end
    n_checks++;
    if (n != 64) begin n_fail++; $display("FAIL timeout_len: got %0d want 64", n); end
    cfg_addr = 8'hE0; #1; n_checks++;
    if ({cfg_rdata, irq_err, cs_n} !== {16'h0810, 1'b1, 5'b11101}) begin
      n_fail++; $display("FAIL timeout_flag: got %h/%b/%b want 0810/1/11101", cfg_rdata, irq_err, cs_n);
    end
    bus_end();
    dev_ready_n = 5'b11111;
    cfg_wr(8'hE0, 16'h0010);
    cfg_addr = 8'hE0; #1; n_checks++;
    if ({cfg_rdata, irq_err} !== {16'h0800, 1'b0}) begin
      n_fail++; $display("FAIL timeout_w1c: got %h/%b want 0800/0", cfg_rdata, irq_err);
    end
  endtask

  task automatic test_nomatch_and_reset();
    cfg_wr(8'h40, 16'h0000);
    bus_start(8'h13, 1'b1);
    cfg_addr = 8'hE0; #1; n_checks++;
    if ({cs_n, ready_n, data_oe_n, irq_err, cfg_rdata} !== {5'b11111, 3'b111, 16'h0820}) begin
      n_fail++; $display("FAIL nomatch: got %b/%b/%b/%b/%h want 11111/1/1/1/0820",
                         cs_n, ready_n, data_oe_n, irq_err, cfg_rdata);
    end
    tick();
    n_checks++;
    if (ready_n !== 1'b1) begin n_fail++; $display("FAIL nomatch_ready: got %b want 1", ready_n); end
    bus_end();
    cfg_wr(8'hE0, 16'h0020);
    cfg_wr(8'h40, 16'h00E1);
    dev_ready_n = 5'b11101;
    bus_start(8'h13, 1'b1);
    n_checks++;
    if ({cs_n, ready_n} !== 6'b11101_0) begin
      n_fail++; $display("FAIL rst_pre: got %b want 111010", {cs_n, ready_n});
    end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({cs_n, ready_n, io_r_w_, data_oe_n, data_dir} !== 9'b11111_1111) begin
      n_fail++; $display("FAIL rst_async: got %b want 111111111", {cs_n, ready_n, io_r_w_, data_oe_n, data_dir});
    end
    #2 iorq_n = 1'b1; dev_ready_n = 5'b11111; rst_n = 1'b1;
    tick();
    cfg_addr = 8'h40; #1; n_checks++;
    if (cfg_rdata !== 16'h0000) begin n_fail++; $display("FAIL rst_attr: got %h want 0000", cfg_rdata); end
  endtask

  initial begin
    test_reset();
    test_cfg_readback();
    test_basic_read();
    test_priority();
    test_write_gating();
    test_wait_states();
    test_timeout();
    test_nomatch_and_reset();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
